regfile_port_arbiter: RTL
=========================

Name: regfile_port_arbiter

Overview:
- Shares the single-port 8x8 register file between two requesters: A (core pipeline) and B (load/debug unit).
- The register file performs exactly one operation per clock: a dual read (two registers, data registered, valid next cycle) or a single write.
- This block selects one requester per cycle, drives the register-file controls, and returns read data to the requester that issued the read.
- Arbitration is round-robin with an optional bounded lock for back-to-back accesses.

Parameters:
- MAX_LOCK, 4, max consecutive cycles a requester may hold the port via lock (1..15)
- A_FIRST, 1, after reset the priority pointer favours A (1) or B (0)

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- a_req, b_req  in  1  request valid for this cycle
- a_we, b_we  in  1  1 = write, 0 = dual read
- a_lock, b_lock  in  1  request to keep the grant next cycle
- a_raddr1, a_raddr2, b_raddr1, b_raddr2  in  3  read addresses
- a_waddr, b_waddr  in  3  write address
- a_wdata, b_wdata  in  8  write data
- a_gnt, b_gnt  out  1  combinational grant; the operation is performed this cycle
- a_rvalid, b_rvalid  out  1  read data valid, one cycle after a granted read
- a_rdata1, a_rdata2, b_rdata1, b_rdata2  out  8  read results
- rf_r_or_w  out  1  to register file: 0 = read, 1 = write
- rf_r_addr1, rf_r_addr2, rf_w_addr  out  3  to register file
- rf_w_data  out  8  to register file
- rf_data1, rf_data2  in  8  from register file (registered there)

Behaviour:
- Reset (rst_n=0, asynchronous):
  - gnt, rvalid and rdata outputs are all 0.
  - rf_r_or_w=0, all rf addresses 0, rf_w_data=0. No write may reach the register file during reset.
  - State is cleared: prio_ptr=A if A_FIRST else B, lock_owner=none, lock_cnt=0, pend_valid=0.
- Grant (combinational on req and state):
  - Only one request: grant it.
  - Both requesting, lock_owner=none: grant the prio_ptr side.
  - Both requesting, lock_owner=X and X requesting: grant X.
  - Never two grants in one cycle. With no request, both gnt=0.
- Pointer: on each granted cycle (not locked), prio_ptr moves to the non-granted side.
- Lock:
  - If the granted requester has lock=1 and lock_cnt < MAX_LOCK-1: lock_owner=it, lock_cnt++.
  - Otherwise lock_owner=none, lock_cnt=0, and prio_ptr goes to the other side.
  - The lock also drops if the owner deasserts req. The other side then wins its next contested cycle.
- Register-file drive (combinational mux of the granted requester):
  - rf_r_or_w = granted we.
  - Addresses and data are the granted requester's values.
  - No grant: rf_r_or_w=0, addresses 0 (harmless read, result discarded).
- Read return:
  - A granted read at cycle N sets pend_valid=1 and pend_owner at edge N.
  - Cycle N+1: owner's rvalid=1 and rdataX = rf_data1/rf_data2.
  - The non-owner's rdata is forced to 0; any rdata with rvalid=0 is 0.
- Latency and throughput:
  - Write commits at the edge ending the grant cycle.
  - Read data appears in the cycle after the grant.
  - One operation per cycle, so full throughput.
- Read-after-write: a read granted in the cycle after a write (any requester) returns the new value. No bypass is needed.
- Same-cycle conflict: impossible by construction; only one op per cycle.
- Ungranted requesters must hold req and operands until gnt. Grant is the only handshake; no queueing inside.
- Mid-operation reset: a pending rvalid is dropped, and a write whose grant cycle coincides with reset assertion does not commit.

Test Plan:
- Reset then A write r3=0x5A (cycle 1), A read r3,r0 (cycle 2) -> a_gnt both cycles, a_rvalid cycle 3, a_rdata1=0x5A, a_rdata2=0x00, b_rvalid=0.
- A and B both request reads continuously, no lock -> grants alternate A,B,A,B; each rvalid lands exactly one cycle after its grant with the correct owner.
- B holds lock with MAX_LOCK=4 while A requests -> B granted 4 consecutive cycles, then A granted, then B.
- B writes r7=0xFF at cycle N while A reads r7 at cycle N (contended, B prioritised) -> A granted at N+1 and reads 0xFF at N+2.
- No requests for 5 cycles -> rf_r_or_w=0, no gnt, no rvalid; register contents unchanged on a later readback.
- Assert rst_n=0 during a granted B write of r1=0x33 -> r1 not written (readback 0x00), all outputs 0 immediately, grant order restarts from A.

Source files
------------

// File: rtl/regfile_port_arbiter.sv
// Arbitrates a single-port 8x8 register file between requester A (core pipeline)
// and requester B (load/debug unit). One operation per clock: a dual read or a
// single write. Round-robin arbitration with an optional bounded lock.
//
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   {a,b}_req/we/lock              request, 1=write 0=dual read, keep-grant request
//   {a,b}_raddr1/raddr2/waddr      operand addresses (3 bits)
//   {a,b}_wdata                    write data (8 bits)
//   {a,b}_gnt                      combinational grant; the op happens this cycle
//   {a,b}_rvalid, {a,b}_rdata1/2   read return, one cycle after a granted read
//   rf_r_or_w, rf_r_addr1/2,
//   rf_w_addr, rf_w_data           register-file controls (mux of the granted side)
//   rf_data1, rf_data2             registered read data from the register file
module regfile_port_arbiter #(
  parameter int unsigned MAX_LOCK = 4,
  parameter bit          A_FIRST  = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       a_req,
  input  logic       b_req,
  input  logic       a_we,
  input  logic       b_we,
  input  logic       a_lock,
  input  logic       b_lock,
  input  logic [2:0] a_raddr1,
  input  logic [2:0] a_raddr2,
  input  logic [2:0] b_raddr1,
  input  logic [2:0] b_raddr2,
  input  logic [2:0] a_waddr,
  input  logic [2:0] b_waddr,
  input  logic [7:0] a_wdata,
  input  logic [7:0] b_wdata,
  output logic       a_gnt,
  output logic       b_gnt,
  output logic       a_rvalid,
  output logic       b_rvalid,
  output logic [7:0] a_rdata1,
  output logic [7:0] a_rdata2,
  output logic [7:0] b_rdata1,
  output logic [7:0] b_rdata2,
  output logic       rf_r_or_w,
  output logic [2:0] rf_r_addr1,
  output logic [2:0] rf_r_addr2,
  output logic [2:0] rf_w_addr,
  output logic [7:0] rf_w_data,
  input  logic [7:0] rf_data1,
  input  logic [7:0] rf_data2
);

  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {OWN_NONE, OWN_A, OWN_B} owner_t;

  logic             prio_a;
  owner_t           lock_owner;
  logic [CNT_W-1:0] lock_cnt;
  logic             pend_valid;
  logic             pend_a;

  logic             sel_a;
  logic             sel_b;
  logic             gnt_any;
  logic             gnt_we;
  logic             gnt_lock;
  owner_t           gnt_owner;
  logic [CNT_W-1:0] base_cnt;

  logic             prio_a_next;
  owner_t           lock_owner_next;
  logic [CNT_W-1:0] lock_cnt_next;

  // Grant select; held off during reset so nothing reaches the register file.
  always_comb begin
    sel_a = 1'b0;
    sel_b = 1'b0;
    if (rst_n) begin
      if (a_req && b_req) begin
        if (lock_owner == OWN_A)      sel_a = 1'b1;
        else if (lock_owner == OWN_B) sel_b = 1'b1;
        else if (prio_a)              sel_a = 1'b1;
        else                          sel_b = 1'b1;
      end else if (a_req) begin
        sel_a = 1'b1;
      end else if (b_req) begin
        sel_b = 1'b1;
      end
    end
  end

  assign a_gnt     = sel_a;
  assign b_gnt     = sel_b;
  assign gnt_any   = sel_a | sel_b;
  assign gnt_we    = sel_a ? a_we   : b_we;
  assign gnt_lock  = sel_a ? a_lock : b_lock;
  assign gnt_owner = sel_a ? OWN_A  : OWN_B;

  // Register-file drive; idle cycles issue a harmless read of r0.
  always_comb begin
    rf_r_or_w  = 1'b0;
    rf_r_addr1 = '0;
    rf_r_addr2 = '0;
    rf_w_addr  = '0;
    rf_w_data  = '0;
    if (sel_a) begin
      rf_r_or_w  = a_we;
      rf_r_addr1 = a_raddr1;
      rf_r_addr2 = a_raddr2;
      rf_w_addr  = a_waddr;
      rf_w_data  = a_wdata;
    end else if (sel_b) begin
      rf_r_or_w  = b_we;
      rf_r_addr1 = b_raddr1;
      rf_r_addr2 = b_raddr2;
      rf_w_addr  = b_waddr;
      rf_w_data  = b_wdata;
    end
  end

  // Lock/pointer update. A grant to the non-owner means the owner dropped its
  // request, so the streak restarts from zero. The pointer always lands on the
  // side that was not granted, so a released or expired lock hands over.
  always_comb begin
    prio_a_next     = prio_a;
    lock_owner_next = OWN_NONE;
    lock_cnt_next   = '0;
    base_cnt        = (lock_owner == gnt_owner) ? lock_cnt : '0;
    if (gnt_any) begin
      prio_a_next = sel_b;
      if (gnt_lock && (base_cnt < CNT_W'(MAX_LOCK - 1))) begin
        lock_owner_next = gnt_owner;
        lock_cnt_next   = base_cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_a     <= A_FIRST;
      lock_owner <= OWN_NONE;
      lock_cnt   <= '0;
      pend_valid <= 1'b0;
      pend_a     <= 1'b0;
    end else begin
      prio_a     <= prio_a_next;
      lock_owner <= lock_owner_next;
      lock_cnt   <= lock_cnt_next;
      pend_valid <= gnt_any & ~gnt_we;
      pend_a     <= sel_a;
    end
  end

  // Read return: only the owner of the pending read sees data.
  assign a_rvalid = pend_valid & pend_a;
  assign b_rvalid = pend_valid & ~pend_a;
  assign a_rdata1 = a_rvalid ? rf_data1 : '0;
  assign a_rdata2 = a_rvalid ? rf_data2 : '0;
  assign b_rdata1 = b_rvalid ? rf_data1 : '0;
  assign b_rdata2 = b_rvalid ? rf_data2 : '0;

endmodule
